team_06_volume_controller: RTL

//  Sequences the audio volume shifter: holds the user volume level, handles mute, and ramps the applied level one step at a time.

---
 rtl/team_06_vol_pkg.sv | 9 +
 rtl/team_06_ramp_prescaler.sv | 29 ++
 rtl/team_06_volume_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/team_06_vol_pkg.sv
// Shared types and constants for the volume controller slice.
package team_06_vol_pkg;

    localparam int unsigned VOL_W   = 4;
    localparam int unsigned VOL_MAX = (1 << VOL_W) - 1;

    typedef enum logic [1:0] {OFF, RAMP, ACTIVE, STOP} vol_state_t;

endpackage

// File: rtl/team_06_ramp_prescaler.sv
// Divides sample_tick by RAMP_DIV; step pulses on the tick that wraps the counter.
module team_06_ramp_prescaler #(
    parameter int unsigned RAMP_DIV = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic step
);

    localparam int unsigned CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RAMP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign step = tick && !clr && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= step ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/team_06_volume_controller.sv
// Volume sequencer for the audio shifter: user level, mute and fade in/out of the applied level.
// Define VOL_SOFT_RAMP_EN for stepped fades; otherwise the applied level follows in one cycle.
module team_06_volume_controller #(
    parameter int unsigned VOL_W       = 4,
    parameter int unsigned DEFAULT_VOL = 8,
    parameter int unsigned RAMP_DIV    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vol_up,
    input  logic             vol_down,
    input  logic             mute_toggle,
    input  logic             play_active,
    input  logic             sample_tick,
    output logic [VOL_W-1:0] volume,
    output logic             enable_volume,
    output logic [VOL_W-1:0] target_volume,
    output logic             muted,
    output logic             ramping
);

    import team_06_vol_pkg::*;

    vol_state_t       state_q, state_d;
    logic [VOL_W-1:0] vol_d, target_d, eff_target, vol_toward;
    logic             muted_d;

`ifdef VOL_SOFT_RAMP_EN
    logic step, pre_clr;

    assign pre_clr = (state_q == OFF) || (state_q == ACTIVE);

    team_06_ramp_prescaler #(
        .RAMP_DIV(RAMP_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .tick (sample_tick),
        .step (step)
    );
`else
    logic unused_tick;
    localparam int unsigned unused_ramp_div = RAMP_DIV;
    assign unused_tick = sample_tick;
`endif

    assign eff_target = muted ? '0 : target_volume;

    always_comb begin
        vol_toward = volume;
        if (volume < eff_target) begin
            vol_toward = volume + 1'b1;
        end else if (volume > eff_target) begin
            vol_toward = volume - 1'b1;
        end
    end

    always_comb begin
        target_d = target_volume;
        if (vol_up && !vol_down && (target_volume != '1)) begin
            target_d = target_volume + 1'b1;
        end else if (vol_down && !vol_up && (target_volume != '0)) begin
            target_d = target_volume - 1'b1;
        end
        muted_d = muted ^ mute_toggle;

        state_d = state_q;
        vol_d   = volume;
        unique case (state_q)
`ifdef VOL_SOFT_RAMP_EN
            OFF: begin
                vol_d = '0;
                if (play_active) state_d = RAMP;
            end
            RAMP: begin
                if (!play_active) begin
                    state_d = STOP;
                end else begin
                    if (step) vol_d = vol_toward;
                    // Arrival is judged on the post-step level so the last step lands in ACTIVE.
                    if (vol_d == eff_target) state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!play_active) begin
                    state_d = STOP;
                end else if (eff_target != volume) begin
                    state_d = RAMP;
                end
            end
            STOP: begin
                if (play_active) begin
                    state_d = RAMP;
                end else begin
                    if (step && (volume != '0)) vol_d = volume - 1'b1;
                    if (vol_d == '0) state_d = OFF;
                end
            end
`else
            OFF: begin
                vol_d = '0;
                if (play_active) begin
                    vol_d   = eff_target;
                    state_d = RAMP;
                end
            end
            RAMP, ACTIVE: begin
                if (!play_active) begin
                    vol_d   = '0;
                    state_d = OFF;
                end else begin
                    vol_d   = eff_target;
                    state_d = ACTIVE;
                end
            end
            STOP: begin
                vol_d   = '0;
                state_d = OFF;
            end
`endif
            default: begin
                vol_d   = '0;
                state_d = OFF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= OFF;
            volume        <= '0;
            enable_volume <= 1'b0;
            target_volume <= VOL_W'(DEFAULT_VOL);
            muted         <= 1'b0;
            ramping       <= 1'b0;
        end else begin
            state_q       <= state_d;
            volume        <= vol_d;
            enable_volume <= (state_d != OFF);
            target_volume <= target_d;
            muted         <= muted_d;
            ramping       <= (state_d == RAMP) || (state_d == STOP);
        end
    end

endmodule
